// File: rtl/updown_pkg.sv
// Shared constants for the parametrised up/down counter: bound behaviour and count direction encodings.
package updown_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

endpackage

// File: rtl/updown_next.sv
// Combinational next-count logic: one step up or down with bound detection, wrapping to the exact bound or saturating there.
module updown_next
  import updown_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  q,
  input  logic              dir,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  min_val,
  input  logic [WIDTH-1:0]  max_val,
  input  logic              mode,
  output logic [WIDTH-1:0]  next_q,
  output logic              evt
);

  logic [WIDTH:0]   step_x;
  logic [WIDTH:0]   sum_x;
  logic [WIDTH-1:0] step_w;

  assign step_x = (WIDTH+1)'(step);
  assign step_w = WIDTH'(step);
  // Extra top bit keeps q + step from aliasing back below max_val.
  assign sum_x  = {1'b0, q} + step_x;

  always_comb begin
    next_q = q;
    evt    = 1'b0;
    if ((step != '0) && (min_val <= max_val)) begin
      if (dir == DIR_UP) begin
        if (sum_x > {1'b0, max_val}) begin
          evt    = 1'b1;
          next_q = (mode == MODE_SAT) ? max_val : min_val;
        end else begin
          next_q = sum_x[WIDTH-1:0];
        end
      end else begin
        // The subtraction is only evaluated once q >= min_val, so it never underflows.
        if ((q < min_val) || ((q - min_val) < step_w)) begin
          evt    = 1'b1;
          next_q = (mode == MODE_SAT) ? min_val : max_val;
        end else begin
          next_q = q - step_w;
        end
      end
    end
  end

endmodule

// File: rtl/updown_counter_p.sv
// Parametrised up/down counter with load, enable, runtime bounds, wrap/saturate mode, terminal-count pulse and sticky overflow.
module updown_counter_p
  import updown_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               STEP_W  = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              dir,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  min_val,
  input  logic [WIDTH-1:0]  max_val,
  input  logic              mode,
  input  logic              clr_ovf,
  output logic [WIDTH-1:0]  q,
  output logic              at_max,
  output logic              at_min,
  output logic              tc,
  output logic              ovf
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] nxt;
  logic             evt;

  updown_next #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_next (
    .q       (cnt_q),
    .dir     (dir),
    .step    (step),
    .min_val (min_val),
    .max_val (max_val),
    .mode    (mode),
    .next_q  (nxt),
    .evt     (evt)
  );

  // load beats en; a boundary event beats clr_ovf.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    ovf_d = clr_ovf ? 1'b0 : ovf_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = nxt;
      tc_d  = evt;
      if (evt) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RST_VAL;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign q      = cnt_q;
  assign tc     = tc_q;
  assign ovf    = ovf_q;
  assign at_max = (cnt_q == max_val);
  assign at_min = (cnt_q == min_val);

endmodule

// File: tb/tb_updown_counter_p.sv
// Bench for updown_counter_p: directed scenarios with literal expectations plus randomized traffic against an integer model.
module tb_updown_counter_p;

  localparam int W      = 8;
  localparam int SW     = 4;
  localparam int RSTV   = 0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0, dir = 1'b1, load = 1'b0, mode = 1'b0, clr_ovf = 1'b0;
  logic [W-1:0]  load_val = '0, min_val = '0, max_val = '0;
  logic [SW-1:0] step = '0;
  logic [W-1:0]  q;
  logic          at_max, at_min, tc, ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  int m_q   = RSTV;
  bit m_tc  = 1'b0;
  bit m_ovf = 1'b0;

  updown_counter_p #(.WIDTH(W), .STEP_W(SW), .RST_VAL(8'(RSTV))) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .step(step), .min_val(min_val), .max_val(max_val), .mode(mode), .clr_ovf(clr_ovf),
    .q(q), .at_max(at_max), .at_min(at_min), .tc(tc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference behaviour in plain integer arithmetic.
  function automatic void model_step(input int cq, input bit covf, output int nq, output bit ntc, output bit novf);
    int lo, hi, st;
    lo   = int'(min_val);
    hi   = int'(max_val);
    st   = int'(step);
    nq   = cq;
    ntc  = 1'b0;
    novf = clr_ovf ? 1'b0 : covf;
    if (load) begin
      nq = int'(load_val);
    end else if (en && st != 0 && lo <= hi) begin
      if (dir) begin
        if (cq + st > hi) begin
          nq = mode ? hi : lo;
          ntc = 1'b1; novf = 1'b1;
        end else nq = cq + st;
      end else begin
        if (cq < lo + st) begin
          nq = mode ? lo : hi;
          ntc = 1'b1; novf = 1'b1;
        end else nq = cq - st;
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    int nq; bit ntc, novf;
    if (rst) begin
      m_q   <= RSTV;
      m_tc  <= 1'b0;
      m_ovf <= 1'b0;
    end else begin
      model_step(m_q, m_ovf, nq, ntc, novf);
      m_q   <= nq;
      m_tc  <= ntc;
      m_ovf <= novf;
    end
  end

  always @(posedge clk) begin
    #2;
    if (!rst) begin
      chk("model_q",      32'(q),      32'(m_q));
      chk("model_tc",     32'(tc),     32'(m_tc));
      chk("model_ovf",    32'(ovf),    32'(m_ovf));
      chk("model_at_max", 32'(at_max), 32'(m_q == int'(max_val)));
      chk("model_at_min", 32'(at_min), 32'(m_q == int'(min_val)));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input int v);
    load = 1'b1; load_val = 8'(v);
    tick();
    load = 1'b0;
  endtask

  initial begin
    int a, b, t;
    @(negedge clk);
    chk("rst_q", 32'(q), 0);
    chk("rst_tc", 32'(tc), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst = 1'b0;

    // Wrap up across max
    min_val = 10; max_val = 20; step = 3; mode = 1'b0; dir = 1'b1;
    do_load(18);
    chk("wrap_load", 32'(q), 18);
    en = 1'b1; tick();
    chk("wrap_q", 32'(q), 10);
    chk("wrap_tc", 32'(tc), 1);
    chk("wrap_ovf", 32'(ovf), 1);
    tick();
    chk("wrap_q2", 32'(q), 13);
    chk("wrap_tc2", 32'(tc), 0);
    en = 1'b0;

    // Asynchronous reset mid-count
    do_load(37);
    chk("pre_rst_q", 32'(q), 37);
    #2 rst = 1'b1;
    #1;
    chk("arst_q", 32'(q), 0);
    chk("arst_tc", 32'(tc), 0);
    chk("arst_ovf", 32'(ovf), 0);
    @(negedge clk);
    rst = 1'b0;

    // Saturate down at min
    min_val = 5; max_val = 200; step = 4; mode = 1'b1; dir = 1'b0;
    do_load(7);
    en = 1'b1; tick();
    chk("sat_q", 32'(q), 5);
    chk("sat_tc", 32'(tc), 1);
    tick();
    chk("sat_q2", 32'(q), 5);
    chk("sat_tc2", 32'(tc), 1);
    chk("sat_at_min", 32'(at_min), 1);

    // load beats en
    load = 1'b1; load_val = 99; tick();
    load = 1'b0;
    chk("ld_en_q", 32'(q), 99);
    chk("ld_en_tc", 32'(tc), 0);

    // clr_ovf loses to a simultaneous event, then clears alone
    en = 1'b0; do_load(6);
    en = 1'b1; clr_ovf = 1'b1; tick();
    chk("clr_evt_q", 32'(q), 5);
    chk("clr_evt_ovf", 32'(ovf), 1);
    en = 1'b0; tick();
    chk("clr_ovf", 32'(ovf), 0);
    chk("clr_tc", 32'(tc), 0);
    clr_ovf = 1'b0;

    // Out-of-range load then count up in wrap mode
    min_val = 10; max_val = 100; step = 1; mode = 1'b0; dir = 1'b1;
    do_load(250);
    chk("oor_load", 32'(q), 250);
    en = 1'b1; tick();
    chk("oor_q", 32'(q), 10);
    chk("oor_tc", 32'(tc), 1);

    step = 0; tick();
    chk("step0_q", 32'(q), 10);
    chk("step0_tc", 32'(tc), 0);

    step = 1; min_val = 50; max_val = 40; tick();
    chk("inv_q", 32'(q), 10);
    chk("inv_tc", 32'(tc), 0);
    en = 1'b0; do_load(77);
    chk("inv_load", 32'(q), 77);

    // Full-range wrap
    min_val = 0; max_val = 255; step = 1; mode = 1'b0; dir = 1'b1;
    do_load(255);
    chk("full_at_max", 32'(at_max), 1);
    en = 1'b1; tick();
    chk("full_q", 32'(q), 0);
    chk("full_tc", 32'(tc), 1);
    en = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(299) == 0) rst = 1'b1;
      if ($urandom_range(15) == 0) begin
        a = int'($urandom_range(255));
        b = int'($urandom_range(255));
        if ($urandom_range(7) != 0 && a > b) begin t = a; a = b; b = t; end
        min_val = 8'(a); max_val = 8'(b);
      end
      if ($urandom_range(7) == 0) mode = 1'($urandom_range(1));
      step     = 4'($urandom_range(15));
      dir      = 1'($urandom_range(1));
      load     = ($urandom_range(9) == 0);
      load_val = 8'($urandom_range(255));
      en       = ($urandom_range(3) != 0);
      clr_ovf  = ($urandom_range(15) == 0);
      tick();
    end
    rst = 1'b0; en = 1'b0; load = 1'b0; clr_ovf = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_counter_p.md
# updown_counter_p

Parametrised up/down counter: the next generation of the fixed 4-bit up/down counter. It adds configurable width, programmable step, runtime-programmable lower and upper bounds, and wrap or saturate mode at the bounds. It also adds parallel load, count enable, a terminal-count pulse and a sticky overflow flag. It is used as a general-purpose event, address or timer counter inside larger datapath and control blocks.

## Interface
- WIDTH, 8, counter width in bits (≥2)
- STEP_W, 4, step input width in bits (1..WIDTH)
- RST_VAL, 0, value of q after reset (WIDTH bits)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- en  input  1  count enable
- dir  input  1  1 = count up, 0 = count down
- load  input  1  synchronous parallel load strobe
- load_val  input  WIDTH  value taken on load
- step  input  STEP_W  unsigned increment/decrement amount
- min_val  input  WIDTH  lower bound, inclusive
- max_val  input  WIDTH  upper bound, inclusive
- mode  input  1  0 = wrap, 1 = saturate
- clr_ovf  input  1  clears sticky ovf
- q  output  WIDTH  counter value (registered)
- at_max  output  1  q == max_val (combinational from q)
- at_min  output  1  q == min_val (combinational from q)
- tc  output  1  one-cycle terminal-count pulse (registered)
- ovf  output  1  sticky bound-crossing flag (registered)

## Operation
- Priority per clock edge: rst > load > en > hold.
- rst asserted (async): q = RST_VAL, tc = 0, ovf = 0, held while rst is high. RST_VAL is not clamped to the bounds.
- load: q <= load_val, taken verbatim even if outside [min_val, max_val]. tc <= 0. ovf is unchanged except for clr_ovf.
- en=0 and load=0: q holds, tc <= 0.
- Count arithmetic is computed in WIDTH+1 bits, with step zero-extended.
- Up (dir=1): boundary event when q + step > max_val. Otherwise q <= q + step.
- Down (dir=0): boundary event when q < min_val + step, computed without underflow as q − min_val < step when q ≥ min_val. Any q < min_val is always a boundary event. Otherwise q <= q − step.
- Boundary event, wrap mode: q <= min_val when counting up, max_val when counting down. The remainder is discarded, so wrap is to the exact bound, not modular.
- Boundary event, saturate mode: q <= max_val when counting up, min_val when counting down.
- Every boundary event: tc <= 1 for exactly that cycle, ovf <= 1.
- Saturate mode repeats the event on every enabled cycle while pinned: tc stays high and q stays at the bound.
- step = 0 with en=1: q holds, no event, tc <= 0.
- min_val > max_val (invalid config): q holds, no event, tc <= 0. load still works.
- clr_ovf: ovf <= 0. A boundary event in the same cycle wins, so ovf <= 1.
- Bounds, step, mode and dir may change on any cycle. Each edge uses the values sampled at that edge.

## Timing
- Single clock domain. All outputs are registered except at_max and at_min, which decode the q register.
- Latency: q, tc and ovf update on the edge where load or en is sampled.
- tc is high in the cycle following the crossing edge, aligned with the new q.
- Reset deassertion must be synchronous to clk externally. The first count edge is the first clk edge with rst low.

## Structure
- Shared package updown_pkg: mode constants MODE_WRAP = 1'b0 and MODE_SAT = 1'b1, plus the direction constants DIR_UP and DIR_DOWN.
- One combinational sub-module, updown_next. It takes q, dir, step, min_val, max_val and mode, and produces next_q and event. The top holds the registers, the priority logic and the flags.
- No other hierarchy.

## Test plan
- Reset: with RST_VAL=0 and WIDTH=8, assert rst mid-count at q=37, off-edge -> q=0, tc=0 and ovf=0 immediately, without waiting for a clock edge.
- Wrap up: min=10, max=20, step=3, mode=wrap, load 18, then count up -> q goes 18→10 with tc=1 and ovf=1, then 13 with tc=0.
- Saturate down: min=5, max=200, step=4, mode=sat, load 7, then count down -> q=5, tc=1. The next enabled cycle gives q=5, tc=1 again, and at_min=1.
- Priority and edge cases:
  - load=1 and en=1 together with load_val=99 -> q=99, no event.
  - clr_ovf in the same cycle as a boundary event -> ovf stays 1.
  - clr_ovf alone -> ovf=0.
- Out-of-range and degenerate config:
  - load 250 with max=100, count up, wrap mode -> q=min_val, tc=1.
  - step=0 -> q holds.
  - min=50, max=40 -> q holds, tc=0.
- Full-range wrap: min=0, max=255, step=1, up from 255 -> q=0, tc=1. No overflow artefact from the WIDTH+1 arithmetic.
